adf4351_freq_ctrl: RTL and testbench

ADF4351_FREQ_CTRL -- requirements
Module: adf4351_freq_ctrl

---
 rtl/adf4351_pkg.sv | 25 ++
 rtl/adf4351_freq_sat.sv | 43 ++++
 rtl/adf4351_freq_ctrl.sv | 121 ++++++++++++
 tb/tb_adf4351_freq_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/adf4351_pkg.sv
// adf4351_pkg
// Shared definitions for the ADF4351 frequency controller: default frequency
// limits (MHz), the step-size table indexed by step_idx, and the FSM state type.
package adf4351_pkg;

  localparam int F_MIN_DEF  = 35;
  localparam int F_MAX_DEF  = 4400;
  localparam int F_INIT_DEF = 100;

  localparam int FREQ_W = 13;

  // Step sizes in MHz, indexed by step_idx.
  localparam logic [FREQ_W-1:0] STEP_TABLE [4] = '{13'd1, 13'd10, 13'd100, 13'd1000};

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_REQ  = 2'd2
  } state_e;

  function automatic logic [FREQ_W-1:0] step_mhz(input logic [1:0] idx);
    return STEP_TABLE[idx];
  endfunction

endpackage

// File: rtl/adf4351_freq_sat.sv
// adf4351_freq_sat
// Saturating frequency step: returns freq+step clamped to F_MAX when up,
// freq-step clamped to F_MIN when down, and freq unchanged when neither or
// both are requested.
// Ports:
//   freq      current frequency (MHz)
//   step      step size (MHz)
//   up, down  step direction requests
//   freq_next resulting frequency (MHz)
module adf4351_freq_sat #(
  parameter int F_MIN = 35,
  parameter int F_MAX = 4400
) (
  input  logic [12:0] freq,
  input  logic [12:0] step,
  input  logic        up,
  input  logic        down,
  output logic [12:0] freq_next
);

  localparam logic [13:0] F_MIN_W = 14'(F_MIN);
  localparam logic [13:0] F_MAX_W = 14'(F_MAX);

  logic [13:0] sum;
  logic [13:0] diff;

  // One extra bit: the sum cannot wrap, and a negative difference shows up
  // in bit 13 because both operands are below 8192.
  assign sum  = {1'b0, freq} + {1'b0, step};
  assign diff = {1'b0, freq} - {1'b0, step};

  always_comb begin
    freq_next = freq;
    if (up && !down) begin
      if (sum > F_MAX_W) freq_next = F_MAX_W[12:0];
      else               freq_next = sum[12:0];
    end else if (down && !up) begin
      if (diff[13] || (diff < F_MIN_W)) freq_next = F_MIN_W[12:0];
      else                              freq_next = diff[12:0];
    end
  end

endmodule

// File: rtl/adf4351_freq_ctrl.sv
// adf4351_freq_ctrl
// Key-driven frequency setting for an ADF4351 synthesizer. k0/k1 step the
// frequency up/down by the selected step, k2 cycles the step size. Every
// change of frequency is offered downstream through a valid/ready request;
// changes made while a request is outstanding are coalesced into one
// follow-up request carrying the latest frequency.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   k0, k1, k2         one-cycle key pulses (up, down, step select)
//   upd_ready          downstream accepts the pending request
//   freq_mhz, step_idx current setting
//   upd_valid          request pending
//   upd_freq           frequency of the pending request
//
// state   | meaning
// --------+--------------------------------------------------
// INIT    | first cycle after reset, issues the F_INIT request
// IDLE    | no request outstanding
// REQ     | upd_valid high, upd_freq held until handshake
module adf4351_freq_ctrl
  import adf4351_pkg::*;
#(
  parameter int F_MIN  = F_MIN_DEF,
  parameter int F_MAX  = F_MAX_DEF,
  parameter int F_INIT = F_INIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        k0,
  input  logic        k1,
  input  logic        k2,
  input  logic        upd_ready,
  output logic [12:0] freq_mhz,
  output logic [1:0]  step_idx,
  output logic        upd_valid,
  output logic [12:0] upd_freq
);

  localparam logic [12:0] F_INIT_V = 13'(F_INIT);

  state_e      state_q, state_d;
  logic [12:0] freq_q, freq_d;
  logic [1:0]  step_idx_q, step_idx_d;
  logic [12:0] upd_freq_q, upd_freq_d;
  logic        dirty_q, dirty_d;
  logic        change;

  // Arithmetic uses the step in force before any simultaneous k2.
  adf4351_freq_sat #(
    .F_MIN (F_MIN),
    .F_MAX (F_MAX)
  ) u_sat (
    .freq      (freq_q),
    .step      (step_mhz(step_idx_q)),
    .up        (k0),
    .down      (k1),
    .freq_next (freq_d)
  );

  assign change     = (freq_d != freq_q);
  assign step_idx_d = k2 ? step_idx_q + 2'd1 : step_idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      freq_q     <= F_INIT_V;
      step_idx_q <= 2'd0;
      upd_freq_q <= F_INIT_V;
      dirty_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      freq_q     <= freq_d;
      step_idx_q <= step_idx_d;
      upd_freq_q <= upd_freq_d;
      dirty_q    <= dirty_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    upd_freq_d = upd_freq_q;
    dirty_d    = dirty_q;
    case (state_q)
      ST_INIT: begin
        state_d    = ST_REQ;
        upd_freq_d = F_INIT_V;
        // A key hit in this first cycle still needs its own request.
        dirty_d    = change;
      end
      ST_IDLE: begin
        if (change) begin
          state_d    = ST_REQ;
          upd_freq_d = freq_d;
        end
      end
      ST_REQ: begin
        if (upd_ready) begin
          if (dirty_q || change) begin
            upd_freq_d = freq_d;
            dirty_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (change) begin
          dirty_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_comb begin
    upd_valid = (state_q == ST_REQ);
    upd_freq  = upd_freq_q;
    freq_mhz  = freq_q;
    step_idx  = step_idx_q;
  end

endmodule

// File: tb/tb_adf4351_freq_ctrl.sv
module tb_adf4351_freq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        k0, k1, k2, upd_ready;
  logic [12:0] freq_mhz, upd_freq;
  logic [1:0]  step_idx;
  logic        upd_valid;

  int n_vec = 0;
  int n_err = 0;
  int extra_hs = 0;

  logic [12:0] sb[$];
  int m_freq;
  int m_step;

  always #5 clk = ~clk;

  adf4351_freq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .k0        (k0),
    .k1        (k1),
    .k2        (k2),
    .upd_ready (upd_ready),
    .freq_mhz  (freq_mhz),
    .step_idx  (step_idx),
    .upd_valid (upd_valid),
    .upd_freq  (upd_freq)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int step_val(input int idx);
    case (idx)
      0: return 1;
      1: return 10;
      2: return 100;
      default: return 1000;
    endcase
  endfunction

  // Handshake monitor: each accepted request must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && upd_valid && upd_ready) begin
      if (sb.size() == 0) extra_hs++;
      else chk("hs_freq", int'(upd_freq), int'(sb.pop_front()));
    end
  end

  // One key cycle; model update, outputs check, and a request expectation
  // whenever the frequency changes while the writer is ready.
  task automatic press(input logic a0, input logic a1, input logic a2);
    int nf;
    nf = m_freq;
    if (a0 && !a1) nf = (m_freq + step_val(m_step) > 4400) ? 4400 : m_freq + step_val(m_step);
    if (a1 && !a0) nf = (m_freq - step_val(m_step) < 35) ? 35 : m_freq - step_val(m_step);
    @(posedge clk); #1;
    k0 = a0; k1 = a1; k2 = a2;
    @(posedge clk); #1;
    k0 = 1'b0; k1 = 1'b0; k2 = 1'b0;
    if (a2) m_step = (m_step + 1) % 4;
    chk("freq_mhz", int'(freq_mhz), nf);
    chk("step_idx", int'(step_idx), m_step);
    if (nf != m_freq && upd_ready) sb.push_back(13'(nf));
    m_freq = nf;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic press_n(input int n, input logic a0, input logic a1, input logic a2);
    for (int i = 0; i < n; i++) press(a0, a1, a2);
  endtask

  initial begin
    rst = 1'b1; k0 = 1'b0; k1 = 1'b0; k2 = 1'b0; upd_ready = 1'b1;
    m_freq = 100; m_step = 0;
    #12;
    chk("rst_freq", int'(freq_mhz), 100);
    chk("rst_step", int'(step_idx), 0);
    chk("rst_valid", int'(upd_valid), 0);
    chk("rst_updf", int'(upd_freq), 100);

    // Initial request issued one cycle after release, then back to idle.
    sb.push_back(13'd100);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("init_valid", int'(upd_valid), 1);
    chk("init_updf", int'(upd_freq), 100);
    @(posedge clk); #1;
    chk("init_idle", int'(upd_valid), 0);

    // Coalescing with the writer stalled: step 10, three ups from 100.
    press(0, 0, 1);
    upd_ready = 1'b0;
    press(1, 0, 0);
    chk("hold_valid", int'(upd_valid), 1);
    chk("hold_updf1", int'(upd_freq), 110);
    press(1, 0, 0);
    chk("hold_updf2", int'(upd_freq), 110);
    press(1, 0, 0);
    chk("hold_updf3", int'(upd_freq), 110);
    sb.push_back(13'd110);
    sb.push_back(13'd130);
    @(posedge clk); #1;
    upd_ready = 1'b1;
    @(posedge clk); #1;
    chk("coal_valid", int'(upd_valid), 1);
    chk("coal_updf", int'(upd_freq), 130);
    @(posedge clk); #1;
    chk("coal_idle", int'(upd_valid), 0);

    // Back to 100, step to 0, then the full step-index cycle.
    press_n(3, 0, 1, 0);
    press_n(3, 0, 0, 1);
    press_n(4, 0, 0, 1);
    press(1, 0, 1);
    chk("k2k0_freq", int'(freq_mhz), 101);

    // Simultaneous up/down at 40 leaves everything alone.
    press_n(6, 0, 1, 0);
    press_n(3, 0, 0, 1);
    press(0, 1, 0);
    press(1, 1, 0);
    chk("both_freq", int'(freq_mhz), 40);
    chk("both_valid", int'(upd_valid), 0);

    // Lower clamp with the 1000 step.
    press_n(3, 0, 0, 1);
    press(0, 1, 0);
    press(0, 1, 0);
    chk("low_clamp", int'(freq_mhz), 35);

    // Climb to 4350, then clamp at the top; the second up is no change.
    press_n(4, 1, 0, 0);
    press(0, 0, 1);
    press_n(5, 1, 0, 0);
    press(0, 0, 1);
    press(1, 0, 0);
    press(0, 0, 1);
    press_n(3, 1, 0, 0);
    chk("pre_top", int'(freq_mhz), 4350);
    press(1, 0, 0);
    chk("top_clamp", int'(freq_mhz), 4400);
    press(1, 0, 0);
    chk("top_valid", int'(upd_valid), 0);
    chk("sb_drain", sb.size(), 0);
    chk("sb_extra", extra_hs, 0);

    // Reset in the middle of an outstanding request.
    upd_ready = 1'b0;
    press(0, 1, 0);
    chk("mid_valid", int'(upd_valid), 1);
    @(posedge clk); #3;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("arst_valid", int'(upd_valid), 0);
    chk("arst_freq", int'(freq_mhz), 100);
    chk("arst_step", int'(step_idx), 0);
    chk("arst_updf", int'(upd_freq), 100);
    repeat (2) @(posedge clk);
    upd_ready = 1'b1;
    sb.push_back(13'd100);
    m_freq = 100; m_step = 0;
    #3 rst = 1'b0;
    @(posedge clk); #1;
    chk("rein_valid", int'(upd_valid), 1);
    chk("rein_updf", int'(upd_freq), 100);
    repeat (3) @(posedge clk);
    #1;
    chk("end_idle", int'(upd_valid), 0);
    chk("sb_final", sb.size(), 0);
    chk("sb_extra_final", extra_hs, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
